// File: rtl/alu_serial_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
//   - 3-bit ALU command codes as issued by the CPU datapath.
//   - FSM state encoding of the sequencer.
//   - slice_cmd(): maps a latched command onto what the bit slice must execute.
package alu_serial_pkg;

  localparam logic [2:0] ADD_ALU  = 3'd0;
  localparam logic [2:0] SUB_ALU  = 3'd1;
  localparam logic [2:0] XOR_ALU  = 3'd2;
  localparam logic [2:0] SLT_ALU  = 3'd3;
  localparam logic [2:0] AND_ALU  = 3'd4;
  localparam logic [2:0] NAND_ALU = 3'd5;
  localparam logic [2:0] NOR_ALU  = 3'd6;
  localparam logic [2:0] OR_ALU   = 3'd7;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // SLT is a subtraction in the slice; the compare is resolved at finalize.
  function automatic logic [2:0] slice_cmd(input logic [2:0] cmd);
    return (cmd == SLT_ALU) ? SUB_ALU : cmd;
  endfunction

endpackage

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU sequencer: evaluates a WIDTH-bit ALU command on one external 1-bit slice,
// LSB first, one bit per clock, then derives SLT and the status flags.
//
// Optional feature macro: ALU_SERIAL_FLAGS_EN. When undefined, carryout_o, overflow_o and
// zero_o are tied to 0 (SLT still uses the internal subtraction overflow).
//
// Ports:
//   clk_i, reset_i (async, active-high)
//   start_i, command_i[2:0], operand_a_i, operand_b_i  - request side (start sampled in IDLE)
//   busy_o, done_o (1-cycle pulse), result_o, carryout_o, overflow_o, zero_o
//   slice_control_o[2:0], slice_a_o, slice_b_o, slice_carryin_o - drive to the bit slice
//   slice_sum_i, slice_carryout_i                                 - combinational slice outputs
module alu_serial_sequencer
  import alu_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [2:0]       command_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carryout_o,
  output logic             overflow_o,
  output logic             zero_o,
  output logic [2:0]       slice_control_o,
  output logic             slice_a_o,
  output logic             slice_b_o,
  output logic             slice_carryin_o,
  input  logic             slice_sum_i,
  input  logic             slice_carryout_i
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carryout_q, carryout_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic             ovf_sub;
  logic [WIDTH-1:0] res_shifted;
  logic [WIDTH-1:0] fin_res;
  logic             fin_co, fin_ov;

  // Values as they stand once the MSB is captured on this edge.
  assign res_shifted = {slice_sum_i, res_sh_q[WIDTH-1:1]};
  // carry_q is the carry into the MSB during the last RUN cycle.
  assign ovf_sub     = carry_q ^ slice_carryout_i;

  always_comb begin
    fin_res = res_shifted;
    fin_co  = 1'b0;
    fin_ov  = 1'b0;
    unique case (cmd_q)
      ADD_ALU, SUB_ALU: begin
        fin_co = slice_carryout_i;
        fin_ov = ovf_sub;
      end
      // Sign of (a-b) corrected by overflow gives the true signed compare.
      SLT_ALU: fin_res = {{(WIDTH-1){1'b0}}, slice_sum_i ^ ovf_sub};
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    res_sh_d   = res_sh_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RUN;
          cmd_d    = command_i;
          a_sh_d   = operand_a_i;
          b_sh_d   = operand_b_i;
          res_sh_d = '0;
          cnt_d    = '0;
          carry_d  = (command_i == SUB_ALU) || (command_i == SLT_ALU);
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_shifted;
        carry_d  = slice_carryout_i;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = fin_res;
`ifdef ALU_SERIAL_FLAGS_EN
          carryout_d = fin_co;
          overflow_d = fin_ov;
          zero_d     = (fin_res == '0);
`else
          carryout_d = 1'b0;
          overflow_d = 1'b0;
          zero_d     = 1'b0;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_sh_q   <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      res_sh_q   <= res_sh_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  logic running;
  assign running = (state_q == RUN);

  assign busy_o          = running;
  assign done_o          = (state_q == DONE);
  assign result_o        = result_q;
  assign carryout_o      = carryout_q;
  assign overflow_o      = overflow_q;
  assign zero_o          = zero_q;
  assign slice_control_o = running ? slice_cmd(cmd_q) : 3'd0;
  assign slice_a_o       = running & a_sh_q[0];
  assign slice_b_o       = running & b_sh_q[0];
  assign slice_carryin_o = running & carry_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
`timescale 1ns/1ps
module tb_alu_serial_sequencer;
  import alu_serial_pkg::*;

  localparam int W = 32;
`ifdef ALU_SERIAL_FLAGS_EN
  localparam bit FlagsEn = 1'b1;
`else
  localparam bit FlagsEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   command = '0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         busy, done, carryout, overflow, zero;
  logic [W-1:0] result;
  logic [2:0]   slice_control;
  logic         slice_a, slice_b, slice_carryin, slice_sum, slice_carryout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_serial_sequencer #(.WIDTH(W)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .command_i(command),
    .operand_a_i(op_a), .operand_b_i(op_b), .busy_o(busy), .done_o(done),
    .result_o(result), .carryout_o(carryout), .overflow_o(overflow), .zero_o(zero),
    .slice_control_o(slice_control), .slice_a_o(slice_a), .slice_b_o(slice_b),
    .slice_carryin_o(slice_carryin), .slice_sum_i(slice_sum), .slice_carryout_i(slice_carryout)
  );

  // Behavioural 1-bit ALU slice (the external instance the sequencer drives).
  logic bb;
  always_comb begin
    bb             = slice_b ^ (slice_control == SUB_ALU);
    slice_carryout = (slice_a & bb) | (slice_a & slice_carryin) | (bb & slice_carryin);
    case (slice_control)
      XOR_ALU:  slice_sum = slice_a ^ slice_b;
      AND_ALU:  slice_sum = slice_a & slice_b;
      NAND_ALU: slice_sum = ~(slice_a & slice_b);
      NOR_ALU:  slice_sum = ~(slice_a | slice_b);
      OR_ALU:   slice_sum = slice_a | slice_b;
      default:  slice_sum = slice_a ^ bb ^ slice_carryin;
    endcase
  end

  // Word-level reference: what the CPU expects the ALU to produce.
  task automatic ref_calc(input logic [2:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic co, output logic ov,
                          output logic z);
    logic [W:0] s;
    co = 1'b0;
    ov = 1'b0;
    case (cmd)
      ADD_ALU: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0]; co = s[W];
        ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      SUB_ALU: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        r = s[W-1:0]; co = s[W];
        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      SLT_ALU:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      XOR_ALU:  r = a ^ b;
      AND_ALU:  r = a & b;
      NAND_ALU: r = ~(a & b);
      NOR_ALU:  r = ~(a | b);
      default:  r = a | b;
    endcase
    z = (r == 0);
    if (!FlagsEn) begin co = 1'b0; ov = 1'b0; z = 1'b0; end
  endtask

  // Issues one operation and checks latency, slice drive, result and flags.
  // poke=1 also pulses start mid-RUN and during DONE with different operands.
  task automatic run_op(input logic [2:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string nm, input bit poke);
    logic [W-1:0] er;
    logic eco, eov, ez, ecin;
    logic [2:0] ectl;
    int cyc, busy_bad, ctl_bad;
    ref_calc(cmd, a, b, er, eco, eov, ez);
    ectl = (cmd == SLT_ALU) ? SUB_ALU : cmd;
    ecin = (cmd == SUB_ALU) || (cmd == SLT_ALU);
    @(negedge clk);
    start = 1'b1; command = cmd; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; command = 3'($urandom); op_a = $urandom; op_b = $urandom;
    cyc = 1; busy_bad = 0; ctl_bad = 0;
    n_tests++;
    if (slice_carryin !== ecin) begin
      n_fail++; $display("FAIL %s cin_bit0: got %b want %b", nm, slice_carryin, ecin);
    end
    while (done !== 1'b1 && cyc < 2 * W) begin
      if (busy !== 1'b1) busy_bad++;
      if (slice_control !== ectl) ctl_bad++;
      if (poke && cyc == 5) begin start = 1'b1; command = ~cmd; op_a = ~a; op_b = b + 1; end
      else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    n_tests++;
    if (cyc != W + 1 || done !== 1'b1) begin
      n_fail++; $display("FAIL %s latency: got %0d done=%b want %0d", nm, cyc, done, W + 1);
    end
    n_tests++;
    if (busy_bad != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy: bad=%0d busy_at_done=%b want 0/0", nm, busy_bad, busy);
    end
    n_tests++;
    if (ctl_bad != 0 || slice_control !== 3'd0) begin
      n_fail++; $display("FAIL %s slice_control: bad=%0d at_done=%0d", nm, ctl_bad, slice_control);
    end
    n_tests++;
    if ({result, carryout, overflow, zero} !== {er, eco, eov, ez}) begin
      n_fail++;
      $display("FAIL %s result: got %h co%b ov%b z%b want %h co%b ov%b z%b",
               nm, result, carryout, overflow, zero, er, eco, eov, ez);
    end
    if (poke) start = 1'b1;  // sampled while in DONE: must be ignored
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== er) begin
      n_fail++; $display("FAIL %s after_done: done=%b busy=%b res=%h want 0 0 %h",
                         nm, done, busy, result, er);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    n_tests++;
    if ({busy, done, result, carryout, overflow, zero, slice_control, slice_a, slice_b,
         slice_carryin} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: busy=%b done=%b res=%h ctl=%0d want all 0",
                         busy, done, result, slice_control);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_op(ADD_ALU,  32'h7FFFFFFF, 32'h00000001, "add_ovf",  1'b0);
    run_op(SUB_ALU,  32'h00000005, 32'h00000005, "sub_zero", 1'b0);
    run_op(SLT_ALU,  32'hFFFFFFFF, 32'h00000001, "slt_neg",  1'b0);
    run_op(SLT_ALU,  32'h80000000, 32'h00000001, "slt_ovf",  1'b0);
    run_op(SLT_ALU,  32'h00000005, 32'h00000003, "slt_gt",   1'b0);
    run_op(NAND_ALU, 32'hF0F0F0F0, 32'hFF00FF00, "nand",     1'b0);
    run_op(XOR_ALU,  32'h12345678, 32'h12345678, "xor_self", 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = (i % 4 == 0) ? a : $urandom;
      run_op(3'(i % 8), a, b, $sformatf("rand%0d", i), 1'b0);
    end
  endtask

  task automatic test_start_ignored();
    run_op(ADD_ALU, 32'h0000_1234, 32'h0000_4321, "start_ignored", 1'b1);
  endtask

  task automatic test_reset_mid_run();
    int seen;
    run_op(OR_ALU, 32'hA5A5_0000, 32'h0000_5A5A, "pre_abort", 1'b0);
    @(negedge clk);
    start = 1'b1; command = ADD_ALU; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, result, carryout, overflow, zero, slice_control, slice_a, slice_b,
         slice_carryin} !== '0) begin
      n_fail++; $display("FAIL abort_outputs: busy=%b done=%b res=%h ctl=%0d a%b b%b cin%b",
                         busy, done, result, slice_control, slice_a, slice_b, slice_carryin);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (W + 8) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen);
    end
    run_op(ADD_ALU, 32'd3, 32'd4, "add_after_abort", 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
